display_formatter: RTL
======================

# display_formatter

Downstream output stage of the calculator controller. Consumes the controller's `out_cmd`/`out_data` pair and turns each command into a stream of 8-bit ASCII characters for the display/UART sink:
- a number becomes its decimal text;
- an acknowledge becomes a line break.

Binary-to-decimal conversion is a serial double-dabble, so one formatted number occupies the block for several cycles. The `busy` output tells the system when a new command can be taken.

## Interface
- `DATA_W`, default 32: width of `out_data`; equals `` `OD_N ``.
- `DIGITS`, default 10: BCD digits held; must be ≥ ceil(DATA_W·log10(2)).
- `Clock`  in  1  sole clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `out_cmd`  in  `` `OC_N ``  controller output command (`` `OC_NON ``/`` `OC_ACK ``/`` `OC_NUM ``).
- `out_data`  in  DATA_W  number accompanying `` `OC_NUM ``.
- `ch_ready`  in  1  sink accepts a character this cycle.
- `ch_valid`  out  1  `ch_data` is valid.
- `ch_data`  out  8  ASCII character.
- `ch_last`  out  1  marks the final character of the current command.
- `busy`  out  1  block is not in IDLE; commands are not accepted.
- `ovf`  out  1  sticky flag: a non-NON command arrived while busy.

## Operation
- States:
  - IDLE: waiting for a command.
  - CONV: double-dabble conversion.
  - SIGN: emitting '-'.
  - DIGIT: emitting digits.
  - NL: emitting the line break.
- IDLE:
  - `` `OC_NUM `` → latch `out_data`; clear the BCD register; go to CONV.
  - `` `OC_ACK `` → go to NL.
  - `` `OC_NON `` or an undefined code → stay in IDLE.
- CONV:
  - Runs exactly DATA_W iterations.
  - Each iteration: add 3 to every BCD nibble ≥ 5, then shift left one bit, taking in the magnitude MSB.
  - On the last iteration, a priority encoder records the index of the most significant nonzero digit (0 if all digits are zero).
  - Next state: SIGN if the value is negative, otherwise DIGIT.
- SIGN: `ch_data` = 0x2D ('-'), `ch_last` = 0. On handshake → DIGIT.
- DIGIT:
  - `ch_data` = 0x30 + digit[idx], starting from the recorded index and counting down to 0.
  - `ch_last` = 1 when idx = 0.
  - Handshake at idx 0 → IDLE.
  - Leading zeros are never emitted. Value 0 emits a single '0'.
- NL: `ch_data` = 0x0A, `ch_last` = 1. On handshake → IDLE.
- Handshake:
  - A character transfers when `ch_valid` and `ch_ready` are both high.
  - While `ch_valid` is high and `ch_ready` is low, `ch_data` and `ch_last` stay stable.
  - `ch_valid` never drops without a transfer, except on `Reset`.
- Drops:
  - A command is accepted only in IDLE. A non-NON `out_cmd` in any other state is discarded and sets `ovf`.
  - `ovf` clears only on `Reset`.
- Reset, including mid-stream: state → IDLE; `ch_valid`, `ch_last`, `busy`, `ovf` = 0; `ch_data` = 0x00; BCD and data registers = 0. Any partial output is abandoned.

## Timing
- `out_cmd` is sampled at edge T while in IDLE.
- `busy` = 1 from T+1 until the cycle after the final handshake. A command presented during the final-handshake cycle counts as busy: it is dropped and `ovf` is set.
- NUM: CONV occupies cycles T+1 … T+DATA_W. The first character is valid at T+DATA_W+1.
- ACK: newline is valid at T+1.
- Characters are back-to-back: with `ch_ready` held high, one character per cycle and no bubbles, including the SIGN→DIGIT transition.
- Best-case total for an n-character number: DATA_W + n cycles from the accept edge to the return to IDLE.

## Configuration
- `DISPLAY_FORMATTER_SIGNED_EN`:
  - Defined: `out_data` is two's complement. A negative value emits '-', then digits of the magnitude. The magnitude is computed as an unsigned DATA_W-bit negation, so -2^(DATA_W-1) is correct.
  - Undefined: `out_data` is unsigned. SIGN is never entered and no negation logic is built.

## Test plan
- `` `OC_NUM ``, data 123, `ch_ready` = 1: '1','2','3' (0x31, 0x32, 0x33) at T+33..T+35; `ch_last` only on '3'; `busy` low at T+36.
- `` `OC_NUM ``, data 0: single 0x30 with `ch_last` = 1 at T+33. Data 0xFFFFFFFF, SIGNED_EN undefined: 10 characters "4294967295".
- SIGNED_EN defined, data -45 (0xFFFFFFD3): '-','4','5'. Data 0x80000000: "-2147483648", 11 characters.
- `` `OC_ACK ``: 0x0A with `ch_last` = 1 at T+1. With `ch_ready` held low for 5 cycles, the character stays stable and transfers on cycle 6.
- `` `OC_NUM `` 7 accepted, then `` `OC_ACK `` at T+3: ACK dropped, `ovf` = 1 and remains 1; only '7' is emitted.
- `Reset` asserted while the second digit of 123 is pending: the next cycle has `ch_valid` = 0, `busy` = 0, `ovf` = 0. A following `` `OC_NUM `` 9 emits '9' normally.

Source files
------------

// File: rtl/display_formatter.sv
// Turns controller commands into ASCII: numbers as decimal text, acks as newline.
// Optional DISPLAY_FORMATTER_SIGNED_EN treats out_data as two's complement.
`ifndef OC_N
`define OC_N 2
`endif
`ifndef OC_NON
`define OC_NON 2'd0
`endif
`ifndef OC_ACK
`define OC_ACK 2'd1
`endif
`ifndef OC_NUM
`define OC_NUM 2'd2
`endif
`ifndef OD_N
`define OD_N 32
`endif

module display_formatter #(
    parameter int DATA_W = `OD_N,
    parameter int DIGITS = 10
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [`OC_N-1:0]  out_cmd,
    input  logic [DATA_W-1:0] out_data,
    input  logic              ch_ready,
    output logic              ch_valid,
    output logic [7:0]        ch_data,
    output logic              ch_last,
    output logic              busy,
    output logic              ovf
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SIGN,
        DIGIT,
        NL
    } state_t;

    state_t                       state_q, state_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic [DIGITS-1:0][3:0]       bcd_q, bcd_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic [IW-1:0]                idx_q, idx_d;
    logic                         ovf_q, ovf_d;
    logic [DIGITS-1:0][3:0]       bcd_adj;
    logic [DIGITS-1:0][3:0]       bcd_shift;
    logic [IW-1:0]                top_idx;
    logic [DATA_W-1:0]            mag;
    logic                         is_neg;
    logic                         xfer;

`ifdef DISPLAY_FORMATTER_SIGNED_EN
    logic neg_q, neg_d;
    assign is_neg = out_data[DATA_W-1];
    assign mag    = is_neg ? (~out_data + 1'b1) : out_data;
`else
    assign is_neg = 1'b0;
    assign mag    = out_data;
`endif

    // One double-dabble step: add-3 correction, then shift in the magnitude MSB.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[i] >= 4'd5)
                bcd_adj[i] = bcd_q[i] + 4'd3;
        end
        bcd_shift = {bcd_adj[DIGITS-1:0], data_q[DATA_W-1]} >> 0;
        top_idx   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_shift[i] != 4'd0)
                top_idx = IW'(i);
        end
    end

    always_comb begin
        ch_valid = 1'b0;
        ch_data  = 8'h00;
        ch_last  = 1'b0;
        unique case (state_q)
            SIGN: begin
                ch_valid = 1'b1;
                ch_data  = 8'h2D;
            end
            DIGIT: begin
                ch_valid = 1'b1;
                ch_data  = 8'h30 + {4'h0, bcd_q[idx_q]};
                ch_last  = (idx_q == '0);
            end
            NL: begin
                ch_valid = 1'b1;
                ch_data  = 8'h0A;
                ch_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign xfer = ch_valid & ch_ready;
    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
`ifdef DISPLAY_FORMATTER_SIGNED_EN
        neg_d   = neg_q;
`endif
        if (state_q != IDLE && out_cmd != `OC_NON)
            ovf_d = 1'b1;
        unique case (state_q)
            IDLE: begin
                if (out_cmd == `OC_NUM) begin
                    data_d  = mag;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = CONV;
`ifdef DISPLAY_FORMATTER_SIGNED_EN
                    neg_d   = is_neg;
`endif
                end else if (out_cmd == `OC_ACK) begin
                    state_d = NL;
                end
            end
            CONV: begin
                bcd_d  = bcd_shift;
                data_d = data_q << 1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(DATA_W - 1)) begin
                    idx_d   = top_idx;
`ifdef DISPLAY_FORMATTER_SIGNED_EN
                    state_d = neg_q ? SIGN : DIGIT;
`else
                    state_d = DIGIT;
`endif
                end
            end
            SIGN: begin
                if (xfer)
                    state_d = DIGIT;
            end
            DIGIT: begin
                if (xfer) begin
                    if (idx_q == '0)
                        state_d = IDLE;
                    else
                        idx_d = idx_q - 1'b1;
                end
            end
            NL: begin
                if (xfer)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef DISPLAY_FORMATTER_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
`ifdef DISPLAY_FORMATTER_SIGNED_EN
            neg_q   <= neg_d;
`endif
        end
    end

endmodule
